// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Conditions a raw switch/pin input before it reaches the
//               consecutive-value detector FSM.
//               - SYNC_STAGES-deep synchroniser into clk
//               - prescaler that produces a sample tick every PRESCALE
//                 enabled cycles
//               - four-state debouncer that needs DEB_CYCLES agreeing ticks
//                 before it accepts a new level
//               - one-cycle rise/fall strobes on each accepted change
//               - saturating count of rejected candidate changes
// Ports       : clk        system clock, rising edge
//               rst        asynchronous, active-high reset
//               raw_in     unsynchronised raw input
//               en         sampling enable (0 freezes prescaler and FSM)
//               w_out      debounced level (drives downstream FSM w)
//               rise       one-clk strobe on w_out 0->1
//               fall       one-clk strobe on w_out 1->0
//               bouncing   high while a candidate change is being qualified
//               glitch_cnt saturating count of aborted qualifications
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int DEB_W       = 8,
    parameter int PRESCALE    = 1,
    parameter int PS_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    input  logic       en,
    output logic       w_out,
    output logic       rise,
    output logic       fall,
    output logic       bouncing,
    output logic [7:0] glitch_cnt
);

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [7:0]       GLC_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        ST_LO     = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HI     = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [PS_W-1:0]        ps_q;
    state_t                 state_q;
    logic [DEB_W-1:0]       deb_q;
    logic                   w_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [7:0]             glitch_q;

    logic                   s;
    logic                   tick;
    logic [7:0]             glitch_d;

    // ------------------------------------------------------------------
    // Synchroniser: shifts every cycle, independent of en, so the
    // synchronised view stays current while sampling is paused.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Prescaler: wraps at PRESCALE-1; holds its count while en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else if (en) begin
            if (ps_q == PS_LAST) begin
                ps_q <= '0;
            end else begin
                ps_q <= ps_q + PS_W'(1);
            end
        end
    end

    assign tick = en && (ps_q == PS_LAST);

    // Abort increment that sticks at the top value instead of wrapping.
    assign glitch_d = (glitch_q == GLC_MAX) ? GLC_MAX : glitch_q + 8'd1;

    // ------------------------------------------------------------------
    // Debounce FSM. w_out and the strobes are registered here so they
    // change on exactly the same edge as the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_LO;
            deb_q    <= '0;
            w_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            // Strobes last one cycle unless re-armed below.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    ST_LO: begin
                        if (s) begin
                            if (DEB_CYCLES == 1) begin
                                state_q <= ST_HI;
                                w_q     <= 1'b1;
                                rise_q  <= 1'b1;
                            end else begin
                                state_q <= ST_CHK_HI;
                                deb_q   <= DEB_ONE;
                            end
                        end
                    end
                    ST_CHK_HI: begin
                        if (s) begin
                            if (deb_q == DEB_LAST) begin
                                state_q <= ST_HI;
                                deb_q   <= '0;
                                w_q     <= 1'b1;
                                rise_q  <= 1'b1;
                            end else begin
                                deb_q <= deb_q + DEB_ONE;
                            end
                        end else begin
                            state_q  <= ST_LO;
                            deb_q    <= '0;
                            glitch_q <= glitch_d;
                        end
                    end
                    ST_HI: begin
                        if (!s) begin
                            if (DEB_CYCLES == 1) begin
                                state_q <= ST_LO;
                                w_q     <= 1'b0;
                                fall_q  <= 1'b1;
                            end else begin
                                state_q <= ST_CHK_LO;
                                deb_q   <= DEB_ONE;
                            end
                        end
                    end
                    ST_CHK_LO: begin
                        if (!s) begin
                            if (deb_q == DEB_LAST) begin
                                state_q <= ST_LO;
                                deb_q   <= '0;
                                w_q     <= 1'b0;
                                fall_q  <= 1'b1;
                            end else begin
                                deb_q <= deb_q + DEB_ONE;
                            end
                        end else begin
                            state_q  <= ST_HI;
                            deb_q    <= '0;
                            glitch_q <= glitch_d;
                        end
                    end
                    default: begin
                        state_q <= ST_LO;
                        deb_q   <= '0;
                        w_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_out      = w_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign bouncing   = (state_q == ST_CHK_HI) || (state_q == ST_CHK_LO);
    assign glitch_cnt = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner. Two instances:
//               defaults, and PRESCALE=3 / DEB_CYCLES=2. A reference model
//               tracks the accepted level and the length of the current
//               disagreeing run of sample ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    logic raw_in;
    logic en;

    logic       w0, r0, f0, b0;
    logic [7:0] g0;
    logic       w1, r1, f1, b1;
    logic [7:0] g1;

    always #5 clk = ~clk;

    input_conditioner dut (
        .clk(clk), .rst(rst), .raw_in(raw_in), .en(en),
        .w_out(w0), .rise(r0), .fall(f0), .bouncing(b0), .glitch_cnt(g0)
    );

    input_conditioner #(
        .SYNC_STAGES(SYNC), .DEB_CYCLES(2), .DEB_W(8), .PRESCALE(3), .PS_W(16)
    ) dut_ps (
        .clk(clk), .rst(rst), .raw_in(raw_in), .en(en),
        .w_out(w1), .rise(r1), .fall(f1), .bouncing(b1), .glitch_cnt(g1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: level, run of disagreeing ticks, abort count.
    // ------------------------------------------------------------------
    logic [7:0] hist;
    logic       m_lvl [2];
    int         m_run [2];
    int         m_glc [2];
    logic       m_rise[2];
    logic       m_fall[2];
    int         m_encnt[2];

    function automatic int deb_of(input int m);
        return (m == 0) ? 4 : 2;
    endfunction

    function automatic int pre_of(input int m);
        return (m == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        hist = '0;
        for (int m = 0; m < 2; m++) begin
            m_lvl[m] = 1'b0; m_run[m] = 0; m_glc[m] = 0;
            m_rise[m] = 1'b0; m_fall[m] = 1'b0; m_encnt[m] = 0;
        end
    endtask

    task automatic model_step();
        logic s;
        logic tk;
        if (rst) begin
            model_reset();
            return;
        end
        // raw_in sampled SYNC edges ago is what the debouncer sees now.
        s = hist[SYNC-1];
        for (int m = 0; m < 2; m++) begin
            tk = en && ((m_encnt[m] % pre_of(m)) == pre_of(m) - 1);
            if (en) m_encnt[m]++;
            m_rise[m] = 1'b0;
            m_fall[m] = 1'b0;
            if (tk) begin
                if (s != m_lvl[m]) begin
                    m_run[m]++;
                    if (m_run[m] == deb_of(m)) begin
                        m_lvl[m] = s;
                        m_run[m] = 0;
                        if (s) m_rise[m] = 1'b1;
                        else   m_fall[m] = 1'b1;
                    end
                end else if (m_run[m] > 0) begin
                    m_run[m] = 0;
                    if (m_glc[m] < 255) m_glc[m]++;
                end
            end
        end
        hist = {hist[6:0], raw_in};
    endtask

    task automatic compare_model();
        check("model dut", {4'h0, w0, r0, f0, b0, g0},
              {4'h0, m_lvl[0], m_rise[0], m_fall[0], (m_run[0] > 0), 8'(m_glc[0])});
        check("model dut_ps", {4'h0, w1, r1, f1, b1, g1},
              {4'h0, m_lvl[1], m_rise[1], m_fall[1], (m_run[1] > 0), 8'(m_glc[1])});
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (!rst) compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table for the default instance.
    // ------------------------------------------------------------------
    typedef struct {
        logic       raw;
        logic       w;
        logic       r;
        logic       f;
        logic       b;
        logic [7:0] g;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic raw, input logic w, input logic r,
                                input logic f, input logic b, input logic [7:0] g);
        vec_t v;
        v.raw = raw; v.w = w; v.r = r; v.f = f; v.b = b; v.g = g;
        return v;
    endfunction

    int lat;
    int hold;
    int saw_fall;

    initial begin
        // 0 -> 1 held: bouncing edges 3-5, w/rise on edge 6
        tbl[0]  = mk(1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 1, 1, 0, 0, 0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0);
        // 1 -> 0 held: fall on edge 6
        tbl[8]  = mk(0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 0, 1, 0);
        tbl[11] = mk(0, 1, 0, 0, 1, 0);
        tbl[12] = mk(0, 1, 0, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0);
        // 2-clk pulse: qualified on edges 3-4, aborted on edge 5
        tbl[16] = mk(1, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 1);
        tbl[21] = mk(0, 0, 0, 0, 0, 1);

        rst = 1'b1; raw_in = 1'b0; en = 1'b1;
        model_reset();
        cyc();
        cyc();
        check("reset state dut",    {4'h0, w0, r0, f0, b0, g0}, 16'h0);
        check("reset state dut_ps", {4'h0, w1, r1, f1, b1, g1}, 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) cyc();
        check("idle 20 clks", {4'h0, w0, r0, f0, b0, g0}, 16'h0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 22; i++) begin
            raw_in = tbl[i].raw;
            cyc();
            check($sformatf("table row %0d", i), {4'h0, w0, r0, f0, b0, g0},
                  {4'h0, tbl[i].w, tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].g});
        end

        // ---- prescaled instance: change lands within 6..8 clks ----
        do_reset();
        raw_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (w1 && lat == 0) lat = k;
        end
        check("prescale latency in 6..8", {15'h0, (lat >= 6 && lat <= 8)}, 16'h1);

        // ---- en frozen mid-qualification ----
        do_reset();
        raw_in = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        check("freeze entry b/w", {14'h0, b0, w0}, 16'h2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        check("frozen b/w", {14'h0, b0, w0}, 16'h2);
        en = 1'b1;
        cyc();
        check("resume 1 b/w", {14'h0, b0, w0}, 16'h2);
        cyc();
        check("resume 2 w/rise", {14'h0, w0, r0}, 16'h3);

        // ---- low glitch while high, then reset during CHK_LO ----
        for (int k = 0; k < 4; k++) cyc();
        raw_in = 1'b0; cyc(); cyc();
        raw_in = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        check("high-side glitch count", {8'h0, g0}, 16'h1);
        raw_in = 1'b0;
        cyc(); cyc(); cyc();
        check("in CHK_LO b/w", {14'h0, b0, w0}, 16'h3);
        #2 rst = 1'b1;
        #1 check("async reset outputs", {4'h0, w0, r0, f0, b0, g0}, 16'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        saw_fall = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (f0) saw_fall = 1;
        end
        check("no fall after reset", 16'(saw_fall), 16'h0);

        // ---- randomized run against the model ----
        do_reset();
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                raw_in = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            en = ($urandom_range(0, 9) != 0);
            cyc();
        end
        en = 1'b1;

        // ---- glitch counter saturation ----
        do_reset();
        raw_in = 1'b0;
        for (int p = 0; p < 300; p++) begin
            raw_in = 1'b1; cyc(); cyc();
            raw_in = 1'b0; cyc(); cyc(); cyc(); cyc();
        end
        check("glitch saturation", {8'h0, g0}, 16'h00FF);
        check("no level after glitches", {15'h0, w0}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
